// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HI
    } uart_state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // shift the raw input through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first, one stop bit.
// Optional parity bit is compiled in with the macro UART_RX_PARITY_EN;
// without it parity_err is tied low.
module uart_rx_ovs #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err
);

    import uart_pkg::*;

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_M1   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_ovs: illegal parameter set");
    end

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;
    logic                 sample;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // START samples half a bit after t0; every later sample is a full bit later
    assign sample = (state_q == START) ? (tick_q == HALF_M1) : (tick_q == BIT_M1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (sample) state_d = rx_s ? IDLE : DATA;
            DATA: begin
                if (sample && bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:  if (sample) state_d = STOP;
`endif
            STOP:    if (sample) state_d = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_SEL = 1'(PARITY_ODD != uart_pkg::PARITY_EVEN);
    logic par_q, par_d;
    logic perr_q, perr_d;
`endif

    // counters, shift register and result registers, driven by the current state
    always_comb begin
        tick_d  = sample ? '0 : tick_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE, WAIT_HI: begin
                tick_d = '0;
                bit_d  = '0;
            end
            DATA: begin
                // shifting in from the top leaves bit i at index i after the last bit
                if (sample) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample) par_d = rx_s;
`endif
            STOP: begin
                if (sample) begin
                    done_d = 1'b1;
                    dout_d = shift_q;
                    ferr_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_d = par_q ^ (^shift_q) ^ ODD_SEL;
`endif
                end
            end
            default: ;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: a default instance (16 clk/bit, 8 data bits)
// and a small instance (5 clk/bit, 7 data bits) for back-to-back frames.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

    localparam int CPB0 = 16;
    localparam int DB0  = 8;
    localparam int CPB1 = 5;
    localparam int DB1  = 7;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // line drive of start bit -> rx_done visible: 2 sync + half bit + remaining bits + 1
    localparam int LAT0 = 2 + CPB0 / 2 + (DB0 + PB + 1) * CPB0 + 1;
    localparam int LAT1 = 2 + CPB1 / 2 + (DB1 + PB + 1) * CPB1 + 1;
    localparam int FL1  = (DB1 + PB + 2) * CPB1;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           rx0   = 1'b1;
    logic           rx1   = 1'b1;
    logic [DB0-1:0] dout0;
    logic [DB1-1:0] dout1;
    logic           done0, ferr0, perr0;
    logic           done1, ferr1, perr1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    uart_rx_ovs u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx0),
        .dout       (dout0),
        .rx_done    (done0),
        .frame_err  (ferr0),
        .parity_err (perr0)
    );

    uart_rx_ovs #(
        .CLKS_PER_BIT (CPB1),
        .DATA_BITS    (DB1),
        .PARITY_ODD   (0)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx1),
        .dout       (dout1),
        .rx_done    (done1),
        .frame_err  (ferr1),
        .parity_err (perr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitors, sampled on the falling edge
    int             n0 = 0;
    int             n1 = 0;
    int             c0_last = -1;
    logic [DB0-1:0] d0_last;
    logic           f0_last, p0_last;
    int             c1_q[$];
    logic [DB1-1:0] d1_q[$];

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            n0++;
            c0_last = cyc;
            d0_last = dout0;
            f0_last = ferr0;
            p0_last = perr0;
        end
        if (done1 === 1'b1) begin
            n1++;
            c1_q.push_back(cyc);
            d1_q.push_back(dout1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic line0(input logic v, input int n);
        rx0 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line1(input logic v, input int n);
        rx1 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [DB0-1:0] d, input logic stop, input logic pflip,
                         output int t_start);
        t_start = cyc;
        line0(1'b0, CPB0);
        for (int i = 0; i < DB0; i++) line0(d[i], CPB0);
`ifdef UART_RX_PARITY_EN
        line0((^d) ^ pflip, CPB0);
`endif
        line0(stop, CPB0);
    endtask

    task automatic send1(input logic [DB1-1:0] d);
        line1(1'b0, CPB1);
        for (int i = 0; i < DB1; i++) line1(d[i], CPB1);
`ifdef UART_RX_PARITY_EN
        line1(^d, CPB1);
`endif
        line1(1'b1, CPB1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int             t, nb, base;
        logic           exp_perr;
        logic [DB0-1:0] d;
        int             glitch[2];

        vecs[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'hA3, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0};
        glitch[0] = 3;
        glitch[1] = 7;

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout0", dout0, 0);
        check("rst_done0", done0, 0);
        check("rst_ferr0", ferr0, 0);
        check("rst_perr0", perr0, 0);
        check("rst_dout1", dout1, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // frame table
        for (int i = 0; i < 7; i++) begin
            nb = n0;
            exp_perr = (PB != 0) ? vecs[i].pflip : 1'b0;
            send0(vecs[i].data, vecs[i].stop, vecs[i].pflip, t);
            check($sformatf("v%0d_pulses", i), n0 - nb, 1);
            check($sformatf("v%0d_latency", i), c0_last - t, LAT0);
            check($sformatf("v%0d_dout", i), d0_last, vecs[i].exp_dout);
            check($sformatf("v%0d_ferr", i), f0_last, vecs[i].exp_ferr);
            check($sformatf("v%0d_perr", i), p0_last, exp_perr);
            if (!vecs[i].stop) begin
                line0(1'b0, 100);
                check($sformatf("v%0d_held_low", i), n0 - nb, 1);
                line0(1'b1, 40);
                check($sformatf("v%0d_after_break", i), n0 - nb, 1);
            end else begin
                line0(1'b1, 20);
            end
            check($sformatf("v%0d_dout_hold", i), dout0, vecs[i].exp_dout);
            check($sformatf("v%0d_ferr_hold", i), ferr0, vecs[i].exp_ferr);
        end

        // short glitches on an idle line are false starts
        for (int g = 0; g < 2; g++) begin
            nb = n0;
            line0(1'b0, glitch[g]);
            line0(1'b1, 60);
            check($sformatf("glitch%0d_no_pulse", glitch[g]), n0 - nb, 0);
        end
        nb = n0;
        send0(8'h5A, 1'b1, 1'b0, t);
        check("post_glitch_pulses", n0 - nb, 1);
        check("post_glitch_latency", c0_last - t, LAT0);
        check("post_glitch_dout", d0_last, 8'h5A);
        line0(1'b1, 20);

        // reset in the middle of data bit 4
        nb = n0;
        d = 8'hE7;
        line0(1'b0, CPB0);
        for (int i = 0; i < 4; i++) line0(d[i], CPB0);
        line0(d[4], CPB0 / 2);
        rst_n = 1'b0;
        rx0   = 1'b1;
        #1;
        check("midrst_dout", dout0, 0);
        check("midrst_done", done0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        line0(1'b1, 200);
        check("midrst_no_pulse", n0 - nb, 0);
        send0(8'h3C, 1'b1, 1'b0, t);
        check("after_rst_pulses", n0 - nb, 1);
        check("after_rst_latency", c0_last - t, LAT0);
        check("after_rst_dout", d0_last, 8'h3C);
        line0(1'b1, 20);

        // back-to-back frames on the small instance
        nb = n1;
        t = cyc;
        send1(7'h7F);
        send1(7'h01);
        line1(1'b1, 20);
        check("b2b_pulses", n1 - nb, 2);
        if (c1_q.size() >= 2) begin
            base = c1_q.size() - 2;
            check("b2b_first_latency", c1_q[base] - t, LAT1);
            check("b2b_spacing", c1_q[base+1] - c1_q[base], FL1);
            check("b2b_dout0", d1_q[base], 7'h7F);
            check("b2b_dout1", d1_q[base+1], 7'h01);
        end
        check("b2b_ferr", ferr1, 0);
        check("b2b_perr", perr1, 0);
        check("b2b_dout_hold", dout1, 7'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
